// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use interlock and multiply/divide scoreboard
// for an in-order pipeline; produces the global stall and a stall-cycle counter.
//
// state   | meaning
// LU_IDLE | no load-use interlock pending beyond the detect cycle
// LU_WAIT | holding the pipeline for the remaining load-use cycles
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]                ex_src,
    input  logic [NUM_SRC*REG_AW-1:0]                id_src,
    input  logic [NUM_SRC-1:0]                       id_src_used,
    input  logic                                     id_md_op,
    input  logic [REG_AW-1:0]                        ex_rd,
    input  logic                                     ex_regwrite,
    input  logic                                     ex_memread,
    input  logic [NUM_FWD*REG_AW-1:0]                fwd_rd,
    input  logic [NUM_FWD-1:0]                       fwd_regwrite,
    input  logic                                     md_start,
    input  logic [REG_AW-1:0]                        md_rd,
    input  logic                                     flush,
    output logic [NUM_SRC*$clog2(NUM_FWD+1)-1:0]     fwd_sel,
    output logic                                     stall,
    output logic                                     md_busy,
    output logic                                     md_done,
    output logic [15:0]                              stall_cnt
);
    localparam int SELW = $clog2(NUM_FWD + 1);

    localparam logic [0:0] LU_IDLE = 1'b0;
    localparam logic [0:0] LU_WAIT = 1'b1;
    localparam logic [2:0] LU_LOAD = 3'(LOAD_LAT - 1);

    logic [0:0]        lu_state;
    logic [2:0]        lu_cnt;
    logic [7:0]        md_cnt;
    logic [REG_AW-1:0] md_rd_q;
    logic              lu_match;
    logic              md_match;
    logic              lu_hit;
    logic              md_hazard;

    // Youngest stage wins: scanning oldest-to-youngest lets the last hit stand.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_regwrite[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                    (fwd_rd[k*REG_AW +: REG_AW] == ex_src[i*REG_AW +: REG_AW])) begin
                    fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                end
            end
        end
    end

    always_comb begin
        lu_match = 1'b0;
        md_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == ex_rd))
                lu_match = 1'b1;
            if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == md_rd_q))
                md_match = 1'b1;
        end
    end

    assign lu_hit    = ex_memread & ex_regwrite & (ex_rd != '0) & lu_match & ~flush;
    assign md_hazard = md_busy & (id_md_op | ((md_rd_q != '0) & md_match));
    assign stall     = lu_hit | (lu_state == LU_WAIT) | md_hazard;

    // The detect cycle is the first stall cycle, so WAIT covers LOAD_LAT-1 more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_state <= LU_IDLE;
            lu_cnt   <= '0;
        end else if (flush) begin
            lu_state <= LU_IDLE;
            lu_cnt   <= '0;
        end else if (lu_state == LU_IDLE) begin
            if (lu_hit && (LOAD_LAT > 1)) begin
                lu_state <= LU_WAIT;
                lu_cnt   <= LU_LOAD;
            end
        end else begin
            lu_cnt <= lu_cnt - 3'd1;
            if (lu_cnt == 3'd1)
                lu_state <= LU_IDLE;
        end
    end

    // Mul/div scoreboard runs independently of flush; new issues wait for idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_busy <= 1'b0;
            md_cnt  <= '0;
            md_done <= 1'b0;
            md_rd_q <= '0;
        end else begin
            md_done <= 1'b0;
            if (md_busy) begin
                md_cnt <= md_cnt - 8'd1;
                if (md_cnt == 8'd1) begin
                    md_busy <= 1'b0;
                    md_done <= 1'b1;
                end
            end else if (md_start) begin
                md_busy <= 1'b1;
                md_cnt  <= 8'(MD_LAT);
                md_rd_q <= md_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2: source operands per instruction.
REQ-003 SHALL have parameter NUM_FWD, default 2: forwarding stages; index 0 = youngest (EX/MEM), index NUM_FWD-1 = oldest.
REQ-004 SHALL have parameter LOAD_LAT, default 1, range 1..7: load-use stall cycles.
REQ-005 SHALL have parameter MD_LAT, default 8, range 2..255: multiply/divide latency in cycles.
REQ-006 SHALL define local SELW = clog2(NUM_FWD+1).
REQ-007 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_src  in  NUM_SRC*REG_AW  EX-stage source addresses; operand i at bits [i*REG_AW +: REG_AW]
- id_src  in  NUM_SRC*REG_AW  ID-stage source addresses
- id_src_used  in  NUM_SRC  ID operand i actually read
- id_md_op  in  1  ID instruction is multiply/divide
- ex_rd  in  REG_AW  EX-stage destination
- ex_regwrite  in  1  EX instruction writes ex_rd
- ex_memread  in  1  EX instruction is a load
- fwd_rd  in  NUM_FWD*REG_AW  destination per forwarding stage
- fwd_regwrite  in  NUM_FWD  write enable per forwarding stage
- md_start  in  1  mul/div issues this cycle
- md_rd  in  REG_AW  mul/div destination
- flush  in  1  pipeline flush
- fwd_sel  out  NUM_SRC*SELW  per-operand mux select
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- md_busy  out  1  mul/div in flight
- md_done  out  1  one-cycle completion pulse
- stall_cnt  out  16  saturating stall-cycle counter

Function
REQ-008 SHALL drive fwd_sel combinationally: operand i = k+1 for the lowest k with fwd_regwrite[k]=1, fwd_rd[k]!=0 and fwd_rd[k]=ex_src[i]; otherwise 0 (register file).
REQ-009 SHALL never forward for address 0, whatever the write enables.
REQ-010 SHALL detect load-use (lu_hit) when ex_memread=1, ex_regwrite=1, ex_rd!=0, and ex_rd equals some id_src[i] with id_src_used[i]=1.
REQ-011 SHALL implement the load-use FSM with states LU_IDLE and LU_WAIT and a 3-bit counter lu_cnt.
REQ-012 SHALL, in LU_IDLE on lu_hit with LOAD_LAT>1, load lu_cnt=LOAD_LAT-1 and go to LU_WAIT; with LOAD_LAT=1 SHALL stay in LU_IDLE.
REQ-013 SHALL, in LU_WAIT, decrement lu_cnt each cycle and return to LU_IDLE in the cycle lu_cnt reaches 1.
REQ-014 SHALL give each load-use event exactly LOAD_LAT stall cycles, including the detect cycle.
REQ-015 SHALL, on md_start=1 with md_busy=0, register md_rd, set md_busy=1 and load md_cnt (8-bit)=MD_LAT.
REQ-016 SHALL decrement md_cnt each busy cycle; at md_cnt=1 SHALL clear md_busy and pulse md_done for exactly that following cycle.
REQ-017 SHALL ignore md_start while md_busy=1.
REQ-018 SHALL, for md_start with md_rd=0, still run the timing but never match it as a hazard.
REQ-019 SHALL assert md hazard while md_busy=1 if id_md_op=1, or if a used id_src[i] equals the registered md_rd (nonzero).
REQ-020 SHALL drive stall combinationally = lu_hit | (state=LU_WAIT) | md hazard.
REQ-021 SHALL, on flush=1, force LU_IDLE with lu_cnt=0 on the next edge and suppress lu_hit that cycle.
REQ-022 SHALL leave the mul/div scoreboard unaffected by flush.
REQ-023 SHALL increment stall_cnt on each clock with stall=1 and saturate at 16'hFFFF.

Reset
REQ-024 SHALL, with rst_n=0, immediately force LU_IDLE, lu_cnt=0, md_busy=0, md_cnt=0, md_done=0, stall_cnt=0 and stored md_rd=0, regardless of clk.
REQ-025 SHALL, during reset, keep fwd_sel combinational and drive stall from lu_hit only.
REQ-026 SHALL, on reset asserted mid-stall or mid-mul/div, abandon the operation with no md_done pulse.

Verification
REQ-027 SHALL be checked for forwarding priority: NUM_FWD=2, ex_src[0]=3, fwd_rd={3,3}, fwd_regwrite=2'b11 -> fwd_sel[0]=1; clear fwd_regwrite[0] -> 2; set ex_src[0]=0 -> 0.
REQ-028 SHALL be checked for load-use, LOAD_LAT=2: ex_memread=1, ex_rd=5, id_src[1]=5, id_src_used[1]=1 for one cycle, then bubble -> stall high exactly 2 cycles; with id_src_used[1]=0 -> no stall.
REQ-029 SHALL be checked for mul/div, MD_LAT=4: md_start with md_rd=9 -> md_busy 4 cycles, md_done pulses once on the 5th; ID reading r9 stalls throughout; id_md_op=1 stalls; a second md_start mid-op is ignored.
REQ-030 SHALL be checked for flush: LOAD_LAT=4, flush asserted in cycle 2 of the stall -> stall drops next cycle; a running mul/div still completes.
REQ-031 SHALL be checked for reset and saturation: rst_n low mid-mul/div -> md_busy=0 with no md_done; stall_cnt preloaded near 16'hFFFF via forced stall -> holds at 16'hFFFF.
